apb_timer: RTL
==============

// Module: apb_timer
// PURPOSE
//  APB responder: 32-bit programmable timer on one PSEL line of the AXI-lite-to-APB bridge.
//  Prescaled up-counter with compare/period, one-shot or auto-reload modes, sticky match flag and level IRQ.
//  Registered read data; zero-wait ACCESS phase.
// PARAMETERS
//  C_APB_ADDR_WIDTH  30  PADDR width; only PADDR[4:2] decoded, PSEL performs region select
//  C_APB_DATA_WIDTH  32  PRDATA/PWDATA width
//  PRESC_WIDTH       16  prescaler register/counter width (<= C_APB_DATA_WIDTH)
// PORTS
//  PCLK     in   1                 clock, all logic rising-edge
//  PRESETn  in   1                 reset, synchronous, active-low
//  PSEL     in   1                 select from bridge
//  PENABLE  in   1                 APB access phase
//  PADDR    in   C_APB_ADDR_WIDTH  byte address
//  PWRITE   in   1                 1=write
//  PWDATA   in   C_APB_DATA_WIDTH  write data
//  PRDATA   out  C_APB_DATA_WIDTH  read data, valid in ACCESS
//  PREADY   out  1                 transfer complete
//  PSLVERR  out  1                 error response
//  irq_o    out  1                 level interrupt = STATUS.MATCH & CTRL.IRQ_EN
// BEHAVIOUR
//  Reset (PRESETn=0 at PCLK edge): all registers 0, prescale cnt 0; PRDATA=0, PREADY=1, PSLVERR=0, irq_o=0.
//  Register map (PADDR[4:2]): 0 CTRL {IRQ_EN[2],AUTO_RELOAD[1],EN[0]}; 1 PRESC[PRESC_WIDTH-1:0];
//   2 LOAD[31:0]; 3 COUNT[31:0] R/W; 4 STATUS {MATCH[0]} W1C; 5-7 unmapped (read 0, writes ignored).
//  APB: SETUP = PSEL&!PENABLE -> PRDATA registered from addressed reg (one cycle, not PWRITE);
//   ACCESS = PSEL&PENABLE: PREADY=1, PRDATA holds; write commits at ACCESS edge. Unused bits read 0.
//  PRDATA holds last value when idle; no combinational path PADDR->PRDATA.
//  Prescaler: while EN, pcnt counts 0..PRESC; tick asserted the cycle pcnt==PRESC, pcnt->0. PRESC=0 -> tick every cycle.
//  EN=0: pcnt cleared, COUNT frozen, no ticks.
//  Counter on tick: if COUNT==LOAD -> MATCH<=1; AUTO_RELOAD ? COUNT<=0 : (COUNT holds, CTRL.EN<=0);
//   else COUNT<=COUNT+1 (32-bit wrap only reachable by writing COUNT>LOAD: counts to 0xFFFFFFFF, wraps to 0).
//  LOAD=0 with AUTO_RELOAD: MATCH on every tick.
//  Simultaneous events: APB write to COUNT beats tick update; MATCH set beats W1C clear same cycle;
//   APB write to CTRL beats one-shot EN auto-clear; PRESC write restarts pcnt at 0.
//  Read of COUNT in SETUP returns value before that cycle's tick update.
//  Reset mid-transfer: all state to reset values next edge; bridge retries.
//  irq_o registered-free: combinational AND of two flops, glitch-free.
// CONFIGURATION
//  APB_TIMER_SLVERR_EN defined: ACCESS to offsets 5-7 returns PSLVERR=1 (with PREADY), PRDATA=0;
//   writes to read-only bits remain silently ignored.
//  Not defined: PSLVERR tied 0; unmapped reads 0, writes dropped.
// STRUCTURE
//  apb_timer_pkg: register offset localparams (CTRL/PRESC/LOAD/COUNT/STATUS), CTRL bit indices,
//   typedef ctrl_t packed struct; shared with software headers generator.
//  Sub-module apb_timer_prescaler: EN, PRESC in -> tick out, clears on !EN or PRESC write.
//  Top: APB decode/read mux/PRDATA reg, register file, counter/compare, irq.
// TESTING
//  1 Reset: drive PRESETn=0 2 cycles -> all regs read 0, PREADY=1, irq_o=0.
//  2 R/W: write LOAD=0x1234_5678, read back -> 0x1234_5678 in ACCESS; write PRESC=0xFFFF_FFFF -> reads 0x0000_FFFF.
//  3 Auto-reload: PRESC=3, LOAD=4, CTRL=0x7 -> MATCH and irq_o after 20 cycles, COUNT 0 after; W1C STATUS=1 -> irq_o 0.
//  4 One-shot: PRESC=0, LOAD=2, CTRL=0x1 -> MATCH at 3rd tick, CTRL reads 0, COUNT stays 2.
//  5 Collisions: W1C STATUS on match-set cycle -> MATCH stays 1; write COUNT=0x10 on tick cycle -> reads 0x10.
//  6 Unmapped offset 0x18 write/read -> SLVERR=1 iff APB_TIMER_SLVERR_EN, PRDATA=0, no reg changes.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared register map and control layout for the APB timer.
// Also consumed by the software header generator.
package apb_timer_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_LOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler: one tick every PRESC+1 enabled cycles.
// Count restarts at 0 when disabled or when PRESC is rewritten.
module apb_timer_prescaler #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   restart,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] pcnt;

  assign tick = en & (pcnt == presc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en || restart || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB programmable 32-bit timer with compare, one-shot/auto-reload and IRQ.
// Optional: define APB_TIMER_SLVERR_EN to flag ACCESS to offsets 5-7.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int C_APB_ADDR_WIDTH = 30,
  parameter int C_APB_DATA_WIDTH = 32,
  parameter int PRESC_WIDTH      = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic [C_APB_ADDR_WIDTH-1:0] PADDR,
  input  logic                        PWRITE,
  input  logic [C_APB_DATA_WIDTH-1:0] PWDATA,
  output logic [C_APB_DATA_WIDTH-1:0] PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        irq_o
);

  localparam int DW = C_APB_DATA_WIDTH;

  logic                   setup;
  logic                   access;
  logic                   wr;
  logic [2:0]             addr;
  logic                   sel_ctrl;
  logic                   sel_presc;
  logic                   sel_load;
  logic                   sel_count;
  logic                   sel_status;
  logic                   wr_ctrl;
  logic                   wr_presc;
  logic                   wr_load;
  logic                   wr_count;
  logic                   wr_status;
  logic                   addr_unused;

  ctrl_t                  ctrl;
  logic [PRESC_WIDTH-1:0] presc;
  logic [DW-1:0]          load;
  logic [DW-1:0]          count;
  logic                   match;
  logic                   tick;
  logic                   hit;
  logic [DW-1:0]          rd_mux;

  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign addr   = PADDR[4:2];

  assign addr_unused = ^{PADDR[C_APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign sel_ctrl   = (addr == OFF_CTRL);
  assign sel_presc  = (addr == OFF_PRESC);
  assign sel_load   = (addr == OFF_LOAD);
  assign sel_count  = (addr == OFF_COUNT);
  assign sel_status = (addr == OFF_STATUS);

  assign wr_ctrl   = wr & sel_ctrl;
  assign wr_presc  = wr & sel_presc;
  assign wr_load   = wr & sel_load;
  assign wr_count  = wr & sel_count;
  assign wr_status = wr & sel_status;

  assign PREADY = 1'b1;

`ifdef APB_TIMER_SLVERR_EN
  assign PSLVERR = access & (addr > OFF_STATUS);
`else
  assign PSLVERR = 1'b0;
`endif

  assign irq_o = match & ctrl.irq_en;

  apb_timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .en     (ctrl.en),
    .presc  (presc),
    .restart(wr_presc),
    .tick   (tick)
  );

  assign hit = tick & (count == load);

  // Software writes to CTRL take priority over the one-shot auto-clear.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl  <= '0;
      presc <= '0;
      load  <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= ctrl_t'(PWDATA[2:0]);
      end else if (hit && !ctrl.auto_reload) begin
        ctrl.en <= 1'b0;
      end
      if (wr_presc) begin
        presc <= PWDATA[PRESC_WIDTH-1:0];
      end
      if (wr_load) begin
        load <= PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (wr_count) begin
      count <= PWDATA;
    end else if (hit) begin
      if (ctrl.auto_reload) begin
        count <= '0;
      end
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // A match on the same edge as a W1C clear wins.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (wr_status && PWDATA[0]) begin
      match <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl:   rd_mux[2:0] = ctrl;
      sel_presc:  rd_mux[PRESC_WIDTH-1:0] = presc;
      sel_load:   rd_mux = load;
      sel_count:  rd_mux = count;
      sel_status: rd_mux[0] = match;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PRDATA <= '0;
    end else if (setup) begin
      PRDATA <= rd_mux;
    end
  end

endmodule
